// File: rtl/mantissa_add_normalize_pkg.sv
// fpadd_pkg: shared types and constants for the FP adder's final stage.
package fpadd_pkg;

  localparam int MANT_W = 23;
  localparam int EXP_W  = 8;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    NORM,
    DONE
  } norm_state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

endpackage

// File: rtl/mantissa_add_normalize_if.sv
// Handshake and data bundle for mantissa_add_normalize.
// master = upstream/downstream environment, slave = the stage itself.
interface mantissa_add_normalize_if;
  import fpadd_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              signA;
  logic              signB;
  logic [MANT_W:0]   alignedMantissaA;
  logic [MANT_W:0]   alignedMantissaB;
  logic [EXP_W-1:0]  exponentIn;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       result;
  logic              overflow;
  logic              underflow;

  modport slave (
    input  in_valid, signA, signB, alignedMantissaA, alignedMantissaB,
           exponentIn, out_ready,
    output in_ready, out_valid, result, overflow, underflow
  );

  modport master (
    output in_valid, signA, signB, alignedMantissaA, alignedMantissaB,
           exponentIn, out_ready,
    input  in_ready, out_valid, result, overflow, underflow
  );

endinterface

// File: rtl/mantissa_add_normalize_lzc24.sv
// lzc24: leading-zero count of a 24-bit word; an all-zero word gives 24.
module lzc24 (
  input  logic [23:0] value,
  output logic [4:0]  count
);

  // Scan LSB->MSB so the highest set bit determines the final count.
  always_comb begin
    count = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (value[i]) count = 5'(23 - i);
    end
  end

endmodule

// File: rtl/mantissa_add_normalize.sv
// mantissa_add_normalize: effective add/subtract of aligned mantissas and
// normalization into a packed single-precision word with overflow/underflow.
// Optional macro FPADD_FAST_NORM_EN: single-cycle normalization through a
// leading-zero counter instead of one left shift per cycle.
module mantissa_add_normalize
  import fpadd_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  mantissa_add_normalize_if.slave io
);

  norm_state_t       state;
  logic              signAReg, signBReg, sumSign;
  logic [MANT_W:0]   mantAReg, mantBReg;
  logic [MANT_W+1:0] sum;
  logic [EXP_W-1:0]  expReg, expInc;
  fp32_t             resultReg;
  logic              inReadyReg, outValidReg, overflowReg, underflowReg;

  assign expInc = expReg + 1'b1;

`ifdef FPADD_FAST_NORM_EN
  logic [4:0]        lzc;
  logic [EXP_W-1:0]  lzcExt;
  logic [MANT_W-1:0] shifted;

  lzc24 uLzc (.value(sum[MANT_W:0]), .count(lzc));

  assign lzcExt  = {3'b000, lzc};
  // Bit 23 is known zero on this path, so shifting the low 23 bits is enough.
  assign shifted = sum[MANT_W-1:0] << lzc;
`endif

  assign io.in_ready  = inReadyReg;
  assign io.out_valid = outValidReg;
  assign io.result    = resultReg;
  assign io.overflow  = overflowReg;
  assign io.underflow = underflowReg;

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      inReadyReg   <= 1'b1;
      outValidReg  <= 1'b0;
      resultReg    <= '0;
      overflowReg  <= 1'b0;
      underflowReg <= 1'b0;
      signAReg     <= 1'b0;
      signBReg     <= 1'b0;
      sumSign      <= 1'b0;
      mantAReg     <= '0;
      mantBReg     <= '0;
      sum          <= '0;
      expReg       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            signAReg     <= io.signA;
            signBReg     <= io.signB;
            mantAReg     <= io.alignedMantissaA;
            mantBReg     <= io.alignedMantissaB;
            expReg       <= io.exponentIn;
            overflowReg  <= 1'b0;
            underflowReg <= 1'b0;
            inReadyReg   <= 1'b0;
            state        <= ADD;
          end
        end

        ADD: begin
          if (signAReg == signBReg) begin
            sum     <= {1'b0, mantAReg} + {1'b0, mantBReg};
            sumSign <= signAReg;
          end else if (mantAReg > mantBReg) begin
            sum     <= {1'b0, mantAReg - mantBReg};
            sumSign <= signAReg;
          end else if (mantBReg > mantAReg) begin
            sum     <= {1'b0, mantBReg - mantAReg};
            sumSign <= signBReg;
          end else begin
            // Exact cancellation is a positive zero.
            sum     <= '0;
            sumSign <= 1'b0;
          end
          state <= NORM;
        end

        NORM: begin
          // Default: finish this cycle; the iterative shift path overrides.
          state       <= DONE;
          outValidReg <= 1'b1;
          if (sum == '0) begin
            resultReg <= '0;
          end else if (sum[MANT_W+1]) begin
            if (expInc == EXP_MAX) begin
              resultReg   <= {sumSign, EXP_MAX, {MANT_W{1'b0}}};
              overflowReg <= 1'b1;
            end else begin
              resultReg <= {sumSign, expInc, sum[MANT_W:1]};
            end
          end else if (sum[MANT_W]) begin
            resultReg <= {sumSign, expReg, sum[MANT_W-1:0]};
`ifdef FPADD_FAST_NORM_EN
          end else if (lzcExt >= expReg) begin
            resultReg    <= '0;
            underflowReg <= 1'b1;
          end else begin
            resultReg <= {sumSign, expReg - lzcExt, shifted};
          end
`else
          end else if (expReg == 8'd1) begin
            resultReg    <= '0;
            underflowReg <= 1'b1;
          end else begin
            sum         <= sum << 1;
            expReg      <= expReg - 1'b1;
            state       <= NORM;
            outValidReg <= 1'b0;
          end
`endif
        end

        DONE: begin
          if (io.out_ready) begin
            outValidReg <= 1'b0;
            inReadyReg  <= 1'b1;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mantissa_add_normalize.sv
// Self-checking bench for mantissa_add_normalize: directed corner cases,
// randomized operations against an arithmetic reference, backpressure and
// reset-abort scenarios. Latency counts the accept cycle as cycle 0.
module tb_mantissa_add_normalize;

  logic clk;
  logic reset;
  int   nVec;
  int   nErr;

  mantissa_add_normalize_if io ();

  mantissa_add_normalize dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: sign-magnitude arithmetic, then normalize by counting
  // leading zeros on the integer sum.
  function automatic void refModel(input logic sA, input logic sB,
                                   input logic [23:0] a, input logic [23:0] b,
                                   input logic [7:0] e,
                                   output logic [31:0] r, output logic ov,
                                   output logic un, output int lat);
    int unsigned s;
    int unsigned ma;
    int unsigned mb;
    int          ex;
    int          lz;
    logic        sg;
    ma = a; mb = b; ex = e;
    ov = 1'b0; un = 1'b0; lat = 3; r = '0;
    if (sA == sB) begin s = ma + mb; sg = sA; end
    else if (ma > mb) begin s = ma - mb; sg = sA; end
    else if (mb > ma) begin s = mb - ma; sg = sB; end
    else begin s = 0; sg = 1'b0; end
    if (s == 0) begin
      r = '0;
    end else if (s >= 32'h0100_0000) begin
      ex = (ex + 1) % 256;
      s  = s / 2;
      if (ex == 255) begin r = {sg, 8'hFF, 23'h0}; ov = 1'b1; end
      else r = {sg, 8'(ex), 23'(s)};
    end else begin
      lz = 0;
      while (s < 32'h0080_0000) begin s = s * 2; lz++; end
      if (lz >= ex) begin
        r = '0; un = 1'b1; lat = 3 + ex - 1;
      end else begin
        r = {sg, 8'(ex - lz), 23'(s)}; lat = 3 + lz;
      end
    end
`ifdef FPADD_FAST_NORM_EN
    lat = 3;
`endif
  endfunction

  // Drive one operation, wait for its result and release it.
  task automatic doOp(input logic sA, input logic sB, input logic [23:0] a,
                      input logic [23:0] b, input logic [7:0] e,
                      output logic [31:0] r, output logic ov, output logic un,
                      output int lat);
    int guard;
    io.signA = sA; io.signB = sB;
    io.alignedMantissaA = a; io.alignedMantissaB = b;
    io.exponentIn = e; io.in_valid = 1'b1;
    guard = 0;
    while (!io.in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    nVec++;
    lat = 1;
    while (!io.out_valid && lat < 80) begin @(posedge clk); #1; lat++; end
    if (!io.out_valid) lat = -1;
    r = io.result; ov = io.overflow; un = io.underflow;
    io.out_ready = 1'b1;
    @(posedge clk); #1;
    io.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    if ({io.in_ready, io.out_valid, io.result, io.overflow, io.underflow} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      nErr++;
      $display("FAIL reset_state got rdy=%b vld=%b res=%h ov=%b un=%b want 1 0 00000000 0 0",
               io.in_ready, io.out_valid, io.result, io.overflow, io.underflow);
    end
  endtask

  task automatic test_directed();
    logic [31:0] r;
    logic        ov, un;
    int          lat;
    logic [31:0] expR [5];
    logic        expOv [5];
    logic        expUn [5];
    int          expLat [5];
    logic        sa [5];
    logic        sb [5];
    logic [23:0] ma [5];
    logic [23:0] mb [5];
    logic [7:0]  ex [5];
    sa[0]=0; sb[0]=0; ma[0]=24'h800000; mb[0]=24'h800000; ex[0]=127;
    expR[0]=32'h40000000; expOv[0]=0; expUn[0]=0; expLat[0]=3;
    sa[1]=0; sb[1]=1; ma[1]=24'hC00000; mb[1]=24'h800000; ex[1]=127;
    expR[1]=32'h3F000000; expOv[1]=0; expUn[1]=0;
`ifdef FPADD_FAST_NORM_EN
    expLat[1]=3;
`else
    expLat[1]=4;
`endif
    sa[2]=0; sb[2]=1; ma[2]=24'h900000; mb[2]=24'h900000; ex[2]=100;
    expR[2]=32'h00000000; expOv[2]=0; expUn[2]=0; expLat[2]=3;
    sa[3]=1; sb[3]=1; ma[3]=24'hFFFFFF; mb[3]=24'hFFFFFF; ex[3]=254;
    expR[3]=32'hFF800000; expOv[3]=1; expUn[3]=0; expLat[3]=3;
    sa[4]=0; sb[4]=1; ma[4]=24'h800000; mb[4]=24'h400000; ex[4]=1;
    expR[4]=32'h00000000; expOv[4]=0; expUn[4]=1; expLat[4]=3;
    for (int i = 0; i < 5; i++) begin
      doOp(sa[i], sb[i], ma[i], mb[i], ex[i], r, ov, un, lat);
      if ({r, ov, un} !== {expR[i], expOv[i], expUn[i]}) begin
        nErr++;
        $display("FAIL directed_%0d result got %h ov=%b un=%b want %h ov=%b un=%b",
                 i, r, ov, un, expR[i], expOv[i], expUn[i]);
      end
      if (lat !== expLat[i]) begin
        nErr++;
        $display("FAIL directed_%0d latency got %0d want %0d", i, lat, expLat[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] r, mr;
    logic        ov, un, mov, mun;
    int          lat, mlat;
    logic        sA, sB;
    logic [23:0] a, b;
    logic [7:0]  e;
    int          pick;
    for (int n = 0; n < 200; n++) begin
      a  = 24'h800000 | 24'($urandom);
      b  = (24'h800000 | 24'($urandom)) >> $urandom_range(0, 24);
      sA = 1'($urandom); sB = 1'($urandom);
      pick = $urandom_range(0, 7);
      if (pick == 0) b = a;
      if ($urandom_range(0, 1) == 1) begin
        logic [23:0] t;
        t = a; a = b; b = t;
      end
      if (pick == 1 || pick == 2) e = 8'($urandom_range(1, 8));
      else if (pick == 3) e = 8'd254;
      else e = 8'($urandom_range(1, 254));
      refModel(sA, sB, a, b, e, mr, mov, mun, mlat);
      doOp(sA, sB, a, b, e, r, ov, un, lat);
      if ({r, ov, un} !== {mr, mov, mun}) begin
        nErr++;
        $display("FAIL random_%0d sA=%b sB=%b a=%h b=%h e=%0d got %h ov=%b un=%b want %h ov=%b un=%b",
                 n, sA, sB, a, b, e, r, ov, un, mr, mov, mun);
      end
      if (lat !== mlat) begin
        nErr++;
        $display("FAIL random_%0d latency got %0d want %0d", n, lat, mlat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    int          guard;
    io.signA = 1'b0; io.signB = 1'b0;
    io.alignedMantissaA = 24'hA00000; io.alignedMantissaB = 24'h900000;
    io.exponentIn = 8'd130; io.in_valid = 1'b1;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    nVec++;
    guard = 0;
    while (!io.out_valid && guard < 80) begin @(posedge clk); #1; guard++; end
    // 0xA00000+0x900000 = 0x1300000 -> carry, exp 131, mant 0x180000
    held = {1'b0, 8'd131, 23'h180000};
    if (io.result !== held) begin
      nErr++;
      $display("FAIL bp_result got %h want %h", io.result, held);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if ({io.result, io.in_ready, io.out_valid} !== {held, 1'b0, 1'b1}) begin
        nErr++;
        $display("FAIL bp_hold_%0d got res=%h rdy=%b vld=%b want %h 0 1",
                 c, io.result, io.in_ready, io.out_valid, held);
      end
    end
    io.out_ready = 1'b1;
    @(posedge clk); #1;
    io.out_ready = 1'b0;
    if ({io.in_ready, io.out_valid} !== 2'b10) begin
      nErr++;
      $display("FAIL bp_release got rdy=%b vld=%b want 1 0", io.in_ready, io.out_valid);
    end
  endtask

  task automatic test_reset_norm();
    logic [31:0] r;
    logic        ov, un;
    int          lat;
    int          seen;
    // Difference of 1 needs 23 left shifts, so NORM lasts many cycles.
    io.signA = 1'b0; io.signB = 1'b1;
    io.alignedMantissaA = 24'h800000; io.alignedMantissaB = 24'h7FFFFF;
    io.exponentIn = 8'd127; io.in_valid = 1'b1;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    nVec++;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    if ({io.in_ready, io.out_valid, io.result, io.overflow, io.underflow} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      nErr++;
      $display("FAIL reset_in_norm got rdy=%b vld=%b res=%h ov=%b un=%b want 1 0 00000000 0 0",
               io.in_ready, io.out_valid, io.result, io.overflow, io.underflow);
    end
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (io.out_valid) seen++;
    end
    if (seen !== 0) begin
      nErr++;
      $display("FAIL reset_no_emit got %0d valid cycles want 0", seen);
    end
    doOp(1'b0, 1'b0, 24'h800000, 24'h800000, 8'd127, r, ov, un, lat);
    if ({r, ov, un, lat} !== {32'h40000000, 1'b0, 1'b0, 3}) begin
      nErr++;
      $display("FAIL reset_recover got %h ov=%b un=%b lat=%0d want 40000000 0 0 3", r, ov, un, lat);
    end
  endtask

  initial begin
    nVec = 0; nErr = 0;
    reset = 1'b1;
    io.in_valid = 1'b0; io.out_ready = 1'b0;
    io.signA = 1'b0; io.signB = 1'b0;
    io.alignedMantissaA = '0; io.alignedMantissaB = '0; io.exponentIn = '0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_norm();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
